frac_decim_out_buffer: RTL
==========================

# frac_decim_out_buffer

Elastic output buffer placed directly downstream of the single-MACC fractional decimator. It captures each rounded 18-bit output sample on its single-cycle valid strobe and presents samples to the consumer over a valid/ready handshake. This absorbs the decimator's irregular output cadence and consumer back-pressure. Occupancy and a sticky overflow flag are exported for monitoring.

## Interface

Parameters:

- DataWidth, 18, sample width; matches the decimator output.
- DepthLog2, 4, log2 of buffer depth; Depth = 2**DepthLog2 = 16 entries.

Ports:

- Clk_i  input  1  single clock, shared with the decimator.
- Rst_i  input  1  synchronous, active-high reset.
- Data_i  input  DataWidth  sample from the decimator, signed two's complement.
- DataNd_i  input  1  one-cycle strobe; Data_i is valid this cycle.
- Data_o  output  DataWidth  head-of-buffer sample.
- DataValid_o  output  1  high while the buffer is non-empty.
- DataReady_i  input  1  consumer ready; a transfer occurs when DataValid_o && DataReady_i.
- Level_o  output  DepthLog2+1  number of stored samples, 0..Depth.
- Overflow_o  output  1  sticky; set when a sample is dropped.
- ClrOvf_i  input  1  clears Overflow_o.

## Operation

Storage and pointers:

- Circular RAM of Depth × DataWidth.
- Write pointer and read pointer are DepthLog2 bits wide and wrap modulo Depth.
- Occupancy counter is DepthLog2+1 bits wide.
- Write is accepted when DataNd_i && (Level_o < Depth || pop), where pop = DataValid_o && DataReady_i.
- An accepted write stores Data_i at wrPtr, then increments wrPtr.
- A pop increments rdPtr.

Level_o update per cycle:

- +1 on write only.
- −1 on pop only.
- Unchanged on simultaneous write and pop, or when neither occurs.

Edge conditions:

- Full (Level_o == Depth), DataNd_i high, no pop: sample dropped, pointers and level unchanged, Overflow_o set.
- Full with simultaneous pop: the write is accepted and Level_o stays at Depth.
- Empty: DataReady_i is ignored and no pop occurs.
- Empty with DataNd_i: the sample becomes head on the next cycle.
- Data_o is the sample at rdPtr (first-word fall-through). Data_o holds its last value when empty; its value is don't-care while DataValid_o is low.

Overflow flag:

- Set on a drop, cleared by ClrOvf_i.
- Drop and ClrOvf_i in the same cycle: set wins.

Data path:

- No arithmetic; samples pass bit-exact and in order.
- The DataValid_o-high-to-DataReady_i path is combinational only through the pop decode. There is no combinational path from DataNd_i to any output.

## Timing

- Reset (Rst_i high at a clock edge):
  - wrPtr = rdPtr = 0.
  - Level_o = 0, DataValid_o = 0, Data_o = 0, Overflow_o = 0.
  - Overflow counter = 0 when enabled.
  - RAM contents are not cleared.
- Reset mid-operation discards all stored samples.
- DataNd_i during the reset cycle is ignored.
- Latency: DataNd_i at edge N into an empty buffer gives DataValid_o = 1 and Data_o = sample after edge N, i.e. visible in cycle N+1.
- Pop at edge N: Data_o shows the next sample in cycle N+1. If that pop emptied the buffer, DataValid_o = 0 in cycle N+1.
- DataValid_o is registered and equals (Level_o != 0).
- Sustained throughput is one sample per cycle in and one out.

## Configuration

- Macro FRAC_DECIM_OVF_COUNT_EN.
- Defined:
  - Adds output OvfCount_o [15:0], counting dropped samples.
  - The counter saturates at 16'hFFFF.
  - It is cleared by Rst_i or ClrOvf_i. A drop in the same cycle as ClrOvf_i yields OvfCount_o = 1.
- Undefined: port OvfCount_o and its logic are absent. Overflow_o behaviour is identical in both cases.

## Test plan

- Reset then idle: Rst_i held 2 cycles, no DataNd_i → Level_o = 0, DataValid_o = 0, Data_o = 0, Overflow_o = 0.
- Single pass-through: DataReady_i = 1, DataNd_i with Data_i = 18'h1ABCD at edge 10 → DataValid_o = 1 with Data_o = 18'h1ABCD for exactly cycle 11 only. Level_o returns to 0 at cycle 12.
- Fill, order and wrap:
  - DataReady_i = 0; write 16 samples 1..16 → Level_o = 16.
  - Then DataReady_i = 1 → Data_o reads 1..16 in order on consecutive cycles.
  - Repeat with 20 samples interleaved → pointer wrap verified, order preserved.
- Overflow at full:
  - Level_o = 16, DataReady_i = 0, write 18'h00055 → dropped, Overflow_o = 1, Level_o = 16.
  - Pop the head → the 16th sample is not 18'h00055.
  - ClrOvf_i pulse → Overflow_o = 0.
  - With FRAC_DECIM_OVF_COUNT_EN defined, OvfCount_o = 1 before the clear.
- Full with simultaneous pop and write: Level_o = 16, DataReady_i = 1, DataNd_i = 1 → Level_o stays 16, Overflow_o stays 0, and the new sample emerges 16 pops later.
- Reset mid-stream: Level_o = 7, then Rst_i pulse → Level_o = 0 and DataValid_o = 0 the next cycle. A subsequent write yields Level_o = 1 with the new sample at head.

Source files
------------

// File: rtl/frac_decim_out_buffer_if.sv
// Decimator-to-consumer bus for the output buffer: sample strobe in, valid/ready out, monitoring.
// OvfCount_o is present only when FRAC_DECIM_OVF_COUNT_EN is defined.
interface frac_decim_out_buffer_if #(
  parameter int DataWidth = 18,
  parameter int DepthLog2 = 4
);
  logic [DataWidth-1:0] Data_i;
  logic                 DataNd_i;
  logic [DataWidth-1:0] Data_o;
  logic                 DataValid_o;
  logic                 DataReady_i;
  logic [DepthLog2:0]   Level_o;
  logic                 Overflow_o;
  logic                 ClrOvf_i;
`ifdef FRAC_DECIM_OVF_COUNT_EN
  logic [15:0]          OvfCount_o;

  modport master (
    output Data_i, DataNd_i, DataReady_i, ClrOvf_i,
    input  Data_o, DataValid_o, Level_o, Overflow_o, OvfCount_o
  );

  modport slave (
    input  Data_i, DataNd_i, DataReady_i, ClrOvf_i,
    output Data_o, DataValid_o, Level_o, Overflow_o, OvfCount_o
  );
`else
  modport master (
    output Data_i, DataNd_i, DataReady_i, ClrOvf_i,
    input  Data_o, DataValid_o, Level_o, Overflow_o
  );

  modport slave (
    input  Data_i, DataNd_i, DataReady_i, ClrOvf_i,
    output Data_o, DataValid_o, Level_o, Overflow_o
  );
`endif
endinterface

// File: rtl/frac_decim_out_buffer.sv
// Elastic FWFT buffer after the decimator: a strobed sample is at the head one cycle later; when full and not popped the sample is dropped and the sticky overflow is set.
// FRAC_DECIM_OVF_COUNT_EN adds a saturating 16-bit dropped-sample counter on OvfCount_o.
module frac_decim_out_buffer #(
  parameter int DataWidth = 18,
  parameter int DepthLog2 = 4
) (
  input logic Clk_i,
  input logic Rst_i,
  frac_decim_out_buffer_if.slave bufIf
);
  localparam int Depth = 2 ** DepthLog2;
  localparam logic [DepthLog2:0]   FullLevel = {1'b1, {DepthLog2{1'b0}}};
  localparam logic [DepthLog2:0]   LevelOne  = {{DepthLog2{1'b0}}, 1'b1};
  localparam logic [DepthLog2-1:0] PtrOne    = {{(DepthLog2-1){1'b0}}, 1'b1};

  logic [DataWidth-1:0] ram [Depth];
  logic [DepthLog2-1:0] wrPtr;
  logic [DepthLog2-1:0] rdPtr;
  logic [DepthLog2-1:0] rdPtrNext;
  logic [DepthLog2:0]   level;
  logic [DepthLog2:0]   levelNext;
  logic [DataWidth-1:0] headData;
  logic [DataWidth-1:0] headNext;
  logic                 dataValid;
  logic                 overflow;
  logic                 pop;
  logic                 push;
  logic                 drop;

  always_comb begin
    pop       = dataValid & bufIf.DataReady_i;
    push      = bufIf.DataNd_i & ((level != FullLevel) | pop);
    drop      = bufIf.DataNd_i & ~push;
    rdPtrNext = pop ? rdPtr + PtrOne : rdPtr;

    levelNext = level;
    case ({push, pop})
      2'b10:   levelNext = level + LevelOne;
      2'b01:   levelNext = level - LevelOne;
      default: levelNext = level;
    endcase

    // Head register is preloaded so Data_o never depends on DataNd_i combinationally.
    // An incoming sample bypasses the RAM only when nothing else remains to become head.
    headNext = headData;
    if (levelNext != '0) begin
      if ((level == '0) || (pop && (level == LevelOne))) begin
        headNext = bufIf.Data_i;
      end else begin
        headNext = ram[rdPtrNext];
      end
    end
  end

  always_ff @(posedge Clk_i) begin
    if (push) begin
      ram[wrPtr] <= bufIf.Data_i;
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      level     <= '0;
      dataValid <= 1'b0;
      headData  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PtrOne;
      end
      rdPtr     <= rdPtrNext;
      level     <= levelNext;
      dataValid <= (levelNext != '0);
      headData  <= headNext;
      if (drop) begin
        overflow <= 1'b1;
      end else if (bufIf.ClrOvf_i) begin
        overflow <= 1'b0;
      end
    end
  end

  assign bufIf.Data_o      = headData;
  assign bufIf.DataValid_o = dataValid;
  assign bufIf.Level_o     = level;
  assign bufIf.Overflow_o  = overflow;

`ifdef FRAC_DECIM_OVF_COUNT_EN
  logic [15:0] ovfCount;

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      ovfCount <= '0;
    end else if (bufIf.ClrOvf_i) begin
      ovfCount <= {15'd0, drop};
    end else if (drop && (ovfCount != 16'hFFFF)) begin
      ovfCount <= ovfCount + 16'd1;
    end
  end

  assign bufIf.OvfCount_o = ovfCount;
`endif

endmodule
